mac_sequencer: RTL and testbench
================================

# mac_sequencer

Operand sequencer and controller for the multiply-accumulate unit: computes one N-tap dot product per request by reading coefficients and samples from two synchronous-read memories. It drives the MAC's 2-bit control and both operand buses, then captures the accumulator into a held result register. It sits between the synthesis/IMDCT control FSMs (requesters) and the MAC datapath.

## Interface
- DATA_WIDTH, 16, operand/accumulator width (matches MAC)
- ADDR_WIDTH, 9, coefficient and sample memory address width
- CNT_WIDTH, 6, tap-count width (max taps 2^CNT_WIDTH-1)
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted only in IDLE, or in DONE with result_ready high the same cycle
- tap_count  in  CNT_WIDTH  number of taps N, sampled at accept
- coef_base  in  ADDR_WIDTH  first coefficient address, sampled at accept; stride fixed at 1
- samp_base  in  ADDR_WIDTH  first sample address, sampled at accept
- samp_stride  in  ADDR_WIDTH  sample address increment per tap, sampled at accept (64 for polyphase windowing)
- busy  out  1  high from accept until result handshake
- coef_addr / samp_addr  out  ADDR_WIDTH  registered read addresses
- coef_rd_en / samp_rd_en  out  1  registered read enables, high only on tap-issue cycles
- coef_rdata / samp_rdata  in  DATA_WIDTH  memory read data, valid the cycle after address issue
- mac_control  out  2  MAC opcode: 00 HOLD, 01 CLEAR, 10 LOAD (acc = product), 11 ACC (acc += product)
- mac_data_a / mac_data_b  out  DATA_WIDTH  combinational pass-through of coef_rdata / samp_rdata
- mac_acc_out  in  DATA_WIDTH  MAC accumulator; reflects the opcode applied at the previous edge
- result  out  DATA_WIDTH  captured dot product, held until handshake
- result_valid  out  1  result available; held until result_ready
- result_ready  in  1  consumer accepts result

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch parameters and set tap counter to 0.
  - If N>0: load addresses with the bases, assert rd_en, go to RUN.
  - If N=0: issue CLEAR, go to DRAIN.
- RUN: tap k issues coef_addr = coef_base+k and samp_addr = samp_base+k*samp_stride. Addresses wrap mod 2^ADDR_WIDTH.
  - After issuing tap N-1, deassert rd_en and go to DRAIN.
- Control stage: one-cycle delay register aligns mac_control with returning rdata.
  - Tap 0 gets LOAD; taps 1..N-1 get ACC; every other cycle gets HOLD.
  - No explicit CLEAR is needed because LOAD overwrites.
- DRAIN: wait until the last opcode has been applied (two edges after the last issue), then capture result <= mac_acc_out. Go to DONE.
- DONE: result_valid high, busy high. On result_ready, go to IDLE, or accept a new start in the same cycle (back-to-back).
- start while busy and not in the DONE-handshake case: ignored, no error flag.
- Arithmetic (saturation, Q-format) lives entirely in the MAC; the sequencer never modifies data.
- Reset (including mid-RUN/DRAIN) forces IDLE, aborts the in-flight product, and sets outputs to reset values.

## Timing
- Reset values: busy 0, result_valid 0, result 0, addresses 0, rd_en 0, mac_control HOLD.
- Edge E0 = accept. Tap k address valid after edge Ek; rdata and opcode valid after E(k+1); accumulator updated at E(k+2).
- result and result_valid appear after edge E(N+2), giving latency N+2 cycles.
- N=0: CLEAR applied at E1, result 0 valid after E2.
- Back-to-back throughput: N+3 cycles per dot product (DONE plus accept share a cycle).
- The MAC sees HOLD in every IDLE, DRAIN-wait and DONE cycle, so mac_acc_out stays stable while result_valid is high.

## Structure
- Shared package mac_pkg holds:
  - MAC_HOLD/CLEAR/LOAD/ACC opcode constants
  - DATA_WIDTH default
  - state encoding typedef
- One sub-module, mac_addr_gen: base/stride latches plus two address accumulators. Its outputs are issue-cycle addresses and a last-tap flag.
- The FSM, control delay stage and result capture live in the top level.

## Test plan
- N=3, coef_base 0x010, samp_base 0x020, stride 1:
  - coef addrs 0x010/011/012 and samp addrs 0x020/021/022 after E0..E2
  - mac_control LOAD,ACC,ACC after E1..E3, then HOLD
  - result_valid after E5; result equals a MAC model of sum(coef*samp)
- Stride 64, samp_base 0x1F0, N=4: samp addrs 0x1F0,0x030,0x070,0x0B0 (wrap mod 512).
- N=0: mac_control CLEAR after E0, result 0 valid after E2, no rd_en pulses.
- Hold result_ready low 10 cycles with start pulsed mid-DONE: result stable, start ignored, mac_control HOLD throughout.
- Next start arrives in the same cycle as result_ready: new job accepted with no idle gap, and its first addresses appear after that edge.
- Assert reset at tap 2 of N=8: the next edge gives all reset values and IDLE. A fresh N=2 job then completes correctly.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared opcode, state and width definitions for the MAC operand sequencer.
package mac_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // MAC opcodes as seen on mac_control.
  typedef enum logic [1:0] {
    MAC_HOLD  = 2'b00,
    MAC_CLEAR = 2'b01,
    MAC_LOAD  = 2'b10,
    MAC_ACC   = 2'b11
  } mac_op_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/mac_addr_gen.sv
// Address generator: latches stride and tap count at job accept, then walks
// the coefficient address by 1 and the sample address by the stride per tap.
module mac_addr_gen #(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [CNT_WIDTH-1:0]  tap_count,
  input  logic [ADDR_WIDTH-1:0] coef_base,
  input  logic [ADDR_WIDTH-1:0] samp_base,
  input  logic [ADDR_WIDTH-1:0] samp_stride,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic [ADDR_WIDTH-1:0] samp_addr,
  output logic                  last_tap
);

  logic [ADDR_WIDTH-1:0] coef_addr_reg;
  logic [ADDR_WIDTH-1:0] samp_addr_reg;
  logic [ADDR_WIDTH-1:0] stride_reg;
  logic [CNT_WIDTH-1:0]  last_idx_reg;
  logic [CNT_WIDTH-1:0]  tap_idx_reg;

  // Load bases on accept, step both accumulators on each further tap issue.
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      coef_addr_reg <= '0;
      samp_addr_reg <= '0;
      stride_reg    <= '0;
      last_idx_reg  <= '0;
      tap_idx_reg   <= '0;
    end else if (load) begin
      coef_addr_reg <= coef_base;
      samp_addr_reg <= samp_base;
      stride_reg    <= samp_stride;
      // For N=0 this wraps, but the FSM never consults last_tap in that case.
      last_idx_reg  <= tap_count - 1'b1;
      tap_idx_reg   <= '0;
    end else if (advance) begin
      coef_addr_reg <= coef_addr_reg + 1'b1;
      samp_addr_reg <= samp_addr_reg + stride_reg;
      tap_idx_reg   <= tap_idx_reg + 1'b1;
    end
  end

  assign coef_addr = coef_addr_reg;
  assign samp_addr = samp_addr_reg;
  assign last_tap  = (tap_idx_reg == last_idx_reg);

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: issues N taps of coefficient/sample reads, drives the
// MAC opcode aligned with returning read data, and captures the accumulator.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  tap_count,
  input  logic [ADDR_WIDTH-1:0] coef_base,
  input  logic [ADDR_WIDTH-1:0] samp_base,
  input  logic [ADDR_WIDTH-1:0] samp_stride,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic [ADDR_WIDTH-1:0] samp_addr,
  output logic                  coef_rd_en,
  output logic                  samp_rd_en,
  input  logic [DATA_WIDTH-1:0] coef_rdata,
  input  logic [DATA_WIDTH-1:0] samp_rdata,
  output logic [1:0]            mac_control,
  output logic [DATA_WIDTH-1:0] mac_data_a,
  output logic [DATA_WIDTH-1:0] mac_data_b,
  input  logic [DATA_WIDTH-1:0] mac_acc_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  seq_state_e state_reg;
  seq_state_e state_next;

  logic accept;
  logic advance;
  logic capture;
  logic last_tap;
  logic zero_taps;

  logic                  rd_en_reg;
  mac_op_e               op_pipe_reg;      // opcode of the tap issued this cycle
  mac_op_e               mac_control_reg;  // same opcode, one cycle later
  logic                  drain_wait_reg;
  logic [DATA_WIDTH-1:0] result_reg;

  assign zero_taps = (tap_count == '0);

  mac_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_addr_gen (
    .clock       (clock),
    .reset       (reset),
    .load        (accept),
    .advance     (advance),
    .tap_count   (tap_count),
    .coef_base   (coef_base),
    .samp_base   (samp_base),
    .samp_stride (samp_stride),
    .coef_addr   (coef_addr),
    .samp_addr   (samp_addr),
    .last_tap    (last_tap)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    advance    = 1'b0;
    capture    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = zero_taps ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_tap) state_next = ST_DRAIN;
        else          advance    = 1'b1;
      end
      ST_DRAIN: begin
        // Second DRAIN cycle: the last opcode has reached the accumulator.
        if (!drain_wait_reg) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          if (start) begin
            accept     = 1'b1;
            state_next = zero_taps ? ST_DRAIN : ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read enable, opcode delay stage, drain timer and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_en_reg       <= 1'b0;
      op_pipe_reg     <= MAC_HOLD;
      mac_control_reg <= MAC_HOLD;
      drain_wait_reg  <= 1'b0;
      result_reg      <= '0;
    end else begin
      mac_control_reg <= op_pipe_reg;
      op_pipe_reg     <= MAC_HOLD;
      if (accept) begin
        drain_wait_reg <= 1'b1;
        if (zero_taps) begin
          // No taps: clear directly so the captured result is zero.
          rd_en_reg       <= 1'b0;
          mac_control_reg <= MAC_CLEAR;
        end else begin
          rd_en_reg   <= 1'b1;
          op_pipe_reg <= MAC_LOAD;
        end
      end else if (state_reg == ST_RUN) begin
        if (advance) begin
          rd_en_reg   <= 1'b1;
          op_pipe_reg <= MAC_ACC;
        end else begin
          rd_en_reg      <= 1'b0;
          drain_wait_reg <= 1'b1;
        end
      end else if (state_reg == ST_DRAIN) begin
        drain_wait_reg <= 1'b0;
      end
      if (capture) result_reg <= mac_acc_out;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign result_valid = (state_reg == ST_DONE);
  assign result       = result_reg;
  assign coef_rd_en   = rd_en_reg;
  assign samp_rd_en   = rd_en_reg;
  assign mac_control  = mac_control_reg;
  assign mac_data_a   = coef_rdata;
  assign mac_data_b   = samp_rdata;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench: sequencer with behavioural memories and MAC model.
module tb_mac_sequencer;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] tap_count;
  logic [AW-1:0] coef_base;
  logic [AW-1:0] samp_base;
  logic [AW-1:0] samp_stride;
  logic          busy;
  logic [AW-1:0] coef_addr;
  logic [AW-1:0] samp_addr;
  logic          coef_rd_en;
  logic          samp_rd_en;
  logic [DW-1:0] coef_rdata = '0;
  logic [DW-1:0] samp_rdata = '0;
  logic [1:0]    mac_control;
  logic [DW-1:0] mac_data_a;
  logic [DW-1:0] mac_data_b;
  logic [DW-1:0] mac_acc_out = '0;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          result_ready;

  logic [DW-1:0] coef_mem [0:(1<<AW)-1];
  logic [DW-1:0] samp_mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  mac_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .tap_count    (tap_count),
    .coef_base    (coef_base),
    .samp_base    (samp_base),
    .samp_stride  (samp_stride),
    .busy         (busy),
    .coef_addr    (coef_addr),
    .samp_addr    (samp_addr),
    .coef_rd_en   (coef_rd_en),
    .samp_rd_en   (samp_rd_en),
    .coef_rdata   (coef_rdata),
    .samp_rdata   (samp_rdata),
    .mac_control  (mac_control),
    .mac_data_a   (mac_data_a),
    .mac_data_b   (mac_data_b),
    .mac_acc_out  (mac_acc_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;

  // Synchronous-read memories.
  always @(posedge clock) begin
    if (coef_rd_en) coef_rdata <= coef_mem[coef_addr];
    if (samp_rd_en) samp_rdata <= samp_mem[samp_addr];
  end

  // MAC model (plain wrapping arithmetic; test values never overflow).
  always @(posedge clock) begin
    case (mac_control)
      2'b01:   mac_acc_out <= '0;
      2'b10:   mac_acc_out <= DW'(mac_data_a * mac_data_b);
      2'b11:   mac_acc_out <= DW'(mac_acc_out + mac_data_a * mac_data_b);
      default: mac_acc_out <= mac_acc_out;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_caddr"}, coef_addr, 0);
    check({tag, "_saddr"}, samp_addr, 0);
    check({tag, "_crd"}, coef_rd_en, 0);
    check({tag, "_srd"}, samp_rd_en, 0);
    check({tag, "_ctl"}, mac_control, 2'b00);
  endtask

  task automatic launch(input int n, input int cb, input int sb, input int st);
    start       = 1'b1;
    tap_count   = CW'(n);
    coef_base   = AW'(cb);
    samp_base   = AW'(sb);
    samp_stride = AW'(st);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      coef_mem[i] = '0;
      samp_mem[i] = '0;
    end
    // Job A: 2*5 + 3*6 + 4*7 = 56
    coef_mem[9'h010] = 16'd2;  coef_mem[9'h011] = 16'd3;  coef_mem[9'h012] = 16'd4;
    samp_mem[9'h020] = 16'd5;  samp_mem[9'h021] = 16'd6;  samp_mem[9'h022] = 16'd7;
    // Job B: 1*10 + 2*20 + 3*30 + 4*40 = 300
    coef_mem[9'h100] = 16'd1;  coef_mem[9'h101] = 16'd2;
    coef_mem[9'h102] = 16'd3;  coef_mem[9'h103] = 16'd4;
    samp_mem[9'h1F0] = 16'd10; samp_mem[9'h030] = 16'd20;
    samp_mem[9'h070] = 16'd30; samp_mem[9'h0B0] = 16'd40;
    // Job D: 7*9 + 8*11 = 151
    coef_mem[9'h050] = 16'd7;  coef_mem[9'h051] = 16'd8;
    samp_mem[9'h060] = 16'd9;  samp_mem[9'h062] = 16'd11;
    // Aborted job E data, nonzero so a leaked product would show.
    for (int i = 0; i < 8; i++) begin
      coef_mem[i] = 16'd100;
      samp_mem[i] = 16'd100;
    end

    reset = 1'b1; start = 1'b0; result_ready = 1'b0;
    tap_count = '0; coef_base = '0; samp_base = '0; samp_stride = '0;
    tick(); tick();
    reset = 1'b0;
    check_reset_values("rst");

    // ---- Job A: N=3, stride 1 ----
    launch(3, 'h010, 'h020, 1);
    tick();                                   // E0
    start = 1'b0;
    check("a_e0_caddr", coef_addr, 'h010);
    check("a_e0_saddr", samp_addr, 'h020);
    check("a_e0_rd", coef_rd_en, 1);
    check("a_e0_busy", busy, 1);
    check("a_e0_ctl", mac_control, 2'b00);
    tick();                                   // E1
    check("a_e1_caddr", coef_addr, 'h011);
    check("a_e1_saddr", samp_addr, 'h021);
    check("a_e1_ctl", mac_control, 2'b10);
    tick();                                   // E2
    check("a_e2_caddr", coef_addr, 'h012);
    check("a_e2_saddr", samp_addr, 'h022);
    check("a_e2_ctl", mac_control, 2'b11);
    check("a_e2_rd", samp_rd_en, 1);
    tick();                                   // E3
    check("a_e3_rd", coef_rd_en, 0);
    check("a_e3_ctl", mac_control, 2'b11);
    tick();                                   // E4
    check("a_e4_ctl", mac_control, 2'b00);
    check("a_e4_valid", result_valid, 0);
    tick();                                   // E5
    check("a_e5_valid", result_valid, 1);
    check("a_e5_result", result, 56);
    $display("job A: N=3 result=%0d", result);

    // ---- Hold in DONE for 10 cycles; stray start mid-way is ignored ----
    for (int i = 0; i < 10; i++) begin
      if (i == 5) launch(2, 'h050, 'h060, 2);
      else        start = 1'b0;
      tick();
      check("hold_valid", result_valid, 1);
      check("hold_result", result, 56);
      check("hold_ctl", mac_control, 2'b00);
      check("hold_rd", coef_rd_en, 0);
    end
    start = 1'b0;
    $display("hold: 10 cycles, result=%0d", result);

    // ---- Job B: back-to-back accept with handshake, N=4 stride 64 ----
    launch(4, 'h100, 'h1F0, 64);
    result_ready = 1'b1;
    tick();                                   // E0
    start = 1'b0; result_ready = 1'b0;
    check("b_e0_valid", result_valid, 0);
    check("b_e0_busy", busy, 1);
    check("b_e0_caddr", coef_addr, 'h100);
    check("b_e0_saddr", samp_addr, 'h1F0);
    tick();                                   // E1
    check("b_e1_saddr", samp_addr, 'h030);
    tick();                                   // E2
    check("b_e2_saddr", samp_addr, 'h070);
    tick();                                   // E3
    check("b_e3_saddr", samp_addr, 'h0B0);
    check("b_e3_caddr", coef_addr, 'h103);
    check("b_e3_rd", coef_rd_en, 1);
    tick();                                   // E4
    check("b_e4_rd", coef_rd_en, 0);
    tick();                                   // E5
    check("b_e5_valid", result_valid, 0);
    tick();                                   // E6
    check("b_e6_valid", result_valid, 1);
    check("b_e6_result", result, 300);
    $display("job B: N=4 stride=64 result=%0d", result);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("b_idle_busy", busy, 0);
    check("b_idle_valid", result_valid, 0);

    // ---- Job C: N=0 ----
    launch(0, 'h010, 'h020, 1);
    tick();                                   // E0
    start = 1'b0;
    check("c_e0_ctl", mac_control, 2'b01);
    check("c_e0_rd", coef_rd_en, 0);
    check("c_e0_busy", busy, 1);
    tick();                                   // E1
    check("c_e1_ctl", mac_control, 2'b00);
    check("c_e1_rd", samp_rd_en, 0);
    check("c_e1_valid", result_valid, 0);
    tick();                                   // E2
    check("c_e2_valid", result_valid, 1);
    check("c_e2_result", result, 0);
    check("c_e2_rd", coef_rd_en, 0);
    $display("job C: N=0 result=%0d", result);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // ---- Job E: N=8 aborted by reset at tap 2 ----
    launch(8, 0, 0, 1);
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2: tap 2 address issued
    check("e_tap2_caddr", coef_addr, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("abort");
    $display("job E: aborted by reset");

    // ---- Job D: fresh N=2, stride 2 ----
    launch(2, 'h050, 'h060, 2);
    tick();                                   // E0
    start = 1'b0;
    check("d_e0_saddr", samp_addr, 'h060);
    tick();                                   // E1
    check("d_e1_saddr", samp_addr, 'h062);
    check("d_e1_ctl", mac_control, 2'b10);
    tick();                                   // E2
    check("d_e2_ctl", mac_control, 2'b11);
    tick();                                   // E3
    check("d_e3_valid", result_valid, 0);
    tick();                                   // E4
    check("d_e4_valid", result_valid, 1);
    check("d_e4_result", result, 151);
    $display("job D: N=2 result=%0d", result);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("d_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
